uart_auto_send_gen: RTL and testbench

UART_AUTO_SEND_GEN -- requirements
Module: uart_auto_send_gen

---
 rtl/uart_auto_send_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_auto_send_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_auto_send_gen.sv
// ---------------------------------------------------------------------------
// uart_auto_send_gen
//
// Purpose:
//   Self-contained UART message generator. When started it sends a message
//   of MSG_LEN frames whose bytes are START_BYTE, START_BYTE+1, ... (modulo
//   2^DATA_BITS). Each frame is start bit, DATA_BITS data bits (LSB first),
//   an optional parity bit and STOP_BITS stop bits. Every bit lasts
//   DIV = CLK_FREQ/BAUD clock cycles. In continuous mode the message repeats
//   after GAP_CYCLES idle-high cycles. In single-shot mode the block returns
//   to idle after the message.
//
// Ports:
//   clk        in   system clock, all logic on its rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   level; starts a message when the block is idle
//   mode_cont  in   1 = repeat messages, 0 = single-shot
//   uart_txd   out  registered serial line, idles high
//   busy       out  high whenever the FSM is not idle
//   byte_done  out  one-cycle pulse in the last cycle of each frame
//   msg_done   out  one-cycle pulse in the last cycle of each message
//   msg_count  out  number of completed messages (wraps at 16 bits)
// ---------------------------------------------------------------------------
module uart_auto_send_gen #(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          DATA_BITS  = 8,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1,
  parameter int          MSG_LEN    = 4,
  parameter logic [7:0]  START_BYTE = 8'h41,
  parameter int          GAP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode_cont,
  output logic        uart_txd,
  output logic        busy,
  output logic        byte_done,
  output logic        msg_done,
  output logic [15:0] msg_count
);

  // Cycles per bit; the stop phase is timed as one long interval.
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int STOP_LEN = STOP_BITS * DIV;

  // One shared cycle counter times bits, the stop phase and the gap.
  localparam int CNT_MAX = (STOP_LEN > GAP_CYCLES) ? STOP_LEN : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       baud_cnt_reg;
  logic [BIT_W-1:0]       bit_cnt_reg;
  logic [3:0]             byte_cnt_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   cont_reg;

  logic [DATA_BITS-1:0]   cur_byte;
  logic                   par_bit;
  logic                   bit_end;
  logic                   stop_pre;
  logic                   stop_end;
  logic                   gap_end;
  logic                   last_byte;
  logic                   last_bit;

  // Byte k of a message; the addition wraps naturally at DATA_BITS width.
  assign cur_byte  = DATA_BITS'(START_BYTE) + DATA_BITS'(byte_cnt_reg);

  // Odd mode inverts the XOR reduction so the total count of ones is odd.
  assign par_bit   = (PARITY == 1) ? ~(^cur_byte) : (^cur_byte);

  assign bit_end   = (baud_cnt_reg == CNT_W'(DIV - 1));
  // byte_done/msg_done are registered, so they are armed one cycle early
  // to land exactly in the final stop cycle.
  assign stop_pre  = (baud_cnt_reg == CNT_W'(STOP_LEN - 2));
  assign stop_end  = (baud_cnt_reg == CNT_W'(STOP_LEN - 1));
  assign gap_end   = (baud_cnt_reg == CNT_W'(GAP_CYCLES - 1));
  assign last_byte = (byte_cnt_reg == 4'(MSG_LEN - 1));
  assign last_bit  = (bit_cnt_reg == BIT_W'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      uart_txd     <= 1'b1;
      busy         <= 1'b0;
      byte_done    <= 1'b0;
      msg_done     <= 1'b0;
      msg_count    <= 16'd0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      cont_reg     <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      msg_done  <= 1'b0;

      case (state_reg)
        IDLE: begin
          uart_txd     <= 1'b1;
          busy         <= 1'b0;
          baud_cnt_reg <= '0;
          if (start) begin
            state_reg    <= START;
            uart_txd     <= 1'b0;
            busy         <= 1'b1;
            byte_cnt_reg <= '0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= cur_byte;
            uart_txd     <= cur_byte[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (last_bit) begin
              if (PARITY != 0) begin
                state_reg <= PAR;
                uart_txd  <= par_bit;
              end else begin
                state_reg <= STOP;
                uart_txd  <= 1'b1;
              end
            end else begin
              // shift_reg[0] is the bit currently on the line; [1] is next.
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
              shift_reg   <= shift_reg >> 1;
              uart_txd    <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        PAR: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= STOP;
            uart_txd     <= 1'b1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        STOP: begin
          if (stop_pre) begin
            byte_done <= 1'b1;
            msg_done  <= last_byte;
          end
          if (stop_end) begin
            baud_cnt_reg <= '0;
            if (!last_byte) begin
              // Next frame follows with no idle cycles in between.
              byte_cnt_reg <= byte_cnt_reg + 4'd1;
              state_reg    <= START;
              uart_txd     <= 1'b0;
            end else begin
              msg_count    <= msg_count + 16'd1;
              byte_cnt_reg <= '0;
              if (mode_cont) begin
                state_reg <= GAP;
                cont_reg  <= 1'b1;
              end else begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        GAP: begin
          // Any low sample of mode_cont during the gap cancels the repeat.
          if (!mode_cont) begin
            cont_reg <= 1'b0;
          end
          if (gap_end) begin
            baud_cnt_reg <= '0;
            if (cont_reg && mode_cont) begin
              state_reg <= START;
              uart_txd  <= 1'b0;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_reg    <= IDLE;
          uart_txd     <= 1'b1;
          busy         <= 1'b0;
          baud_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_auto_send_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_auto_send_gen
//
// Five instances with different parameter sets share one clock and reset.
// Expected frames are pushed to a scoreboard queue when a message is started
// and popped by check_frame, which compares the line cycle by cycle against
// the ideal waveform, together with byte_done, msg_done and busy.
// ---------------------------------------------------------------------------
module tb_uart_auto_send_gen;

  localparam int N   = 5;
  localparam int GAP = 1000;

  logic        clk;
  logic        rst_n;
  logic        start_s [N];
  logic        mode_s  [N];
  logic        txd     [N];
  logic        bsy     [N];
  logic        bd      [N];
  logic        md      [N];
  logic [15:0] cnt     [N];

  // Bench-side copy of each instance's parameters.
  int div_a   [N] = '{434, 434, 434, 434, 10};
  int db_a    [N] = '{8, 8, 8, 7, 8};
  int par_a   [N] = '{0, 2, 1, 0, 0};
  int sb_a    [N] = '{1, 1, 1, 2, 1};
  int len_a   [N] = '{4, 1, 1, 2, 2};
  int sbyte_a [N] = '{'h41, 'h41, 'h41, 'h7F, 'h41};

  logic [8:0] exp_q [$];   // {last_of_message, byte}
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_auto_send_gen u_def (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mode_cont(mode_s[0]),
    .uart_txd(txd[0]), .busy(bsy[0]), .byte_done(bd[0]), .msg_done(md[0]),
    .msg_count(cnt[0]));

  uart_auto_send_gen #(.PARITY(2), .MSG_LEN(1)) u_even (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mode_cont(mode_s[1]),
    .uart_txd(txd[1]), .busy(bsy[1]), .byte_done(bd[1]), .msg_done(md[1]),
    .msg_count(cnt[1]));

  uart_auto_send_gen #(.PARITY(1), .MSG_LEN(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .mode_cont(mode_s[2]),
    .uart_txd(txd[2]), .busy(bsy[2]), .byte_done(bd[2]), .msg_done(md[2]),
    .msg_count(cnt[2]));

  uart_auto_send_gen #(.DATA_BITS(7), .STOP_BITS(2), .START_BYTE(8'h7F),
                       .MSG_LEN(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_s[3]), .mode_cont(mode_s[3]),
    .uart_txd(txd[3]), .busy(bsy[3]), .byte_done(bd[3]), .msg_done(md[3]),
    .msg_count(cnt[3]));

  uart_auto_send_gen #(.CLK_FREQ(1000000), .BAUD(100000), .MSG_LEN(2),
                       .GAP_CYCLES(GAP)) u_cont (
    .clk(clk), .rst_n(rst_n), .start(start_s[4]), .mode_cont(mode_s[4]),
    .uart_txd(txd[4]), .busy(bsy[4]), .byte_done(bd[4]), .msg_done(md[4]),
    .msg_count(cnt[4]));

  function automatic logic parity_of(input logic [7:0] b, input int db,
                                     input int mode);
    logic x = 1'b0;
    for (int i = 0; i < db; i++) x ^= b[i];
    return (mode == 1) ? ~x : x;
  endfunction

  // Scoreboard producer: one entry per frame of the message about to start.
  task automatic push_msg(input int idx);
    int v;
    for (int k = 0; k < len_a[idx]; k++) begin
      v = (sbyte_a[idx] + k) % (1 << db_a[idx]);
      exp_q.push_back({(k == len_a[idx] - 1), 8'(v)});
    end
  endtask

  task automatic pulse_start(input int idx);
    @(negedge clk) start_s[idx] = 1'b1;
    @(negedge clk) start_s[idx] = 1'b0;
  endtask

  // Scoreboard consumer. Called at the negedge of the first frame cycle;
  // returns at the negedge of the cycle after the frame.
  task automatic check_frame(input int idx);
    logic [8:0] e;
    logic [7:0] b;
    logic       last, exp_tx;
    int p, len, seg;
    int n_tx = 0, n_bd = 0, n_md = 0, n_busy = 0;
    int c_tx = -1;
    logic g_tx = 1'b0, w_tx = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty dut%0d: got 0 queued frames, want >= 1", idx);
      return;
    end
    e    = exp_q.pop_front();
    b    = e[7:0];
    last = e[8];
    p    = (par_a[idx] != 0) ? 1 : 0;
    len  = (1 + db_a[idx] + p + sb_a[idx]) * div_a[idx];
    for (int c = 0; c < len; c++) begin
      seg = c / div_a[idx];
      if (seg == 0)                              exp_tx = 1'b0;
      else if (seg <= db_a[idx])                 exp_tx = b[seg-1];
      else if (p == 1 && seg == db_a[idx] + 1)   exp_tx = parity_of(b, db_a[idx], par_a[idx]);
      else                                       exp_tx = 1'b1;
      if (txd[idx] !== exp_tx) begin
        if (n_tx == 0) begin c_tx = c; g_tx = txd[idx]; w_tx = exp_tx; end
        n_tx++;
      end
      if (bd[idx]  !== (c == len - 1))          n_bd++;
      if (md[idx]  !== (last && c == len - 1))  n_md++;
      if (bsy[idx] !== 1'b1)                    n_busy++;
      @(negedge clk);
    end
    if (n_tx != 0) begin
      bad++;
      $display("FAIL frame_txd dut%0d byte=%02h: cycle %0d got %b want %b (%0d bad cycles)",
               idx, b, c_tx, g_tx, w_tx, n_tx);
    end
    total++;
    if (n_bd !== 0) begin
      bad++;
      $display("FAIL frame_byte_done dut%0d byte=%02h: got %0d wrong cycles want 0", idx, b, n_bd);
    end
    total++;
    if (n_md !== 0) begin
      bad++;
      $display("FAIL frame_msg_done dut%0d byte=%02h: got %0d wrong cycles want 0", idx, b, n_md);
    end
    total++;
    if (n_busy !== 0) begin
      bad++;
      $display("FAIL frame_busy dut%0d byte=%02h: got %0d low cycles want 0", idx, b, n_busy);
    end
    $display("frame dut%0d byte=%02h last=%0d len=%0d", idx, b, last, len);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      start_s[i] = 1'b1;          // must not be honoured while in reset
      mode_s[i]  = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++;
      if (txd[i] !== 1'b1) begin bad++; $display("FAIL reset_txd dut%0d: got %b want 1", i, txd[i]); end
      total++;
      if (bsy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d: got %b want 0", i, bsy[i]); end
      total++;
      if (bd[i] !== 1'b0 || md[i] !== 1'b0) begin
        bad++; $display("FAIL reset_pulses dut%0d: got bd=%b md=%b want 0 0", i, bd[i], md[i]);
      end
      total++;
      if (cnt[i] !== 16'd0) begin bad++; $display("FAIL reset_count dut%0d: got %0d want 0", i, cnt[i]); end
      start_s[i] = 1'b0;
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++;
      if (bsy[i] !== 1'b0 || txd[i] !== 1'b1) begin
        bad++; $display("FAIL post_reset_idle dut%0d: got busy=%b txd=%b want 0 1", i, bsy[i], txd[i]);
      end
    end
    $display("reset checked");
  endtask

  // Default parameters, single-shot "ABCD"; start is held high through the
  // first frame to show it is ignored while busy.
  task automatic test_single;
    int n_idle = 0;
    exp_q.delete();
    push_msg(0);
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk);
    check_frame(0);
    start_s[0] = 1'b0;
    for (int k = 1; k < 4; k++) check_frame(0);
    total++;
    if (bsy[0] !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", bsy[0]); end
    total++;
    if (cnt[0] !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", cnt[0]); end
    for (int i = 0; i < 100; i++) begin
      if (txd[0] !== 1'b1 || bsy[0] !== 1'b0 || bd[0] !== 1'b0) n_idle++;
      @(negedge clk);
    end
    total++;
    if (n_idle !== 0) begin bad++; $display("FAIL single_idle_after: got %0d bad cycles want 0", n_idle); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL single_queue: got %0d left want 0", exp_q.size()); end
  endtask

  // Reset for one cycle during a data bit, then a clean message.
  task automatic test_reset_mid;
    int n_bad = 0;
    exp_q.delete();
    pulse_start(0);
    repeat (434 * 3 + 100) @(negedge clk);
    total++;
    if (bsy[0] !== 1'b1) begin bad++; $display("FAIL midreset_pre_busy: got %b want 1", bsy[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (txd[0] !== 1'b1) begin bad++; $display("FAIL midreset_txd: got %b want 1", txd[0]); end
    total++;
    if (bsy[0] !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", bsy[0]); end
    total++;
    if (cnt[0] !== 16'd0) begin bad++; $display("FAIL midreset_count: got %0d want 0", cnt[0]); end
    for (int i = 0; i < 500; i++) begin
      if (txd[0] !== 1'b1 || bd[0] !== 1'b0 || md[0] !== 1'b0) n_bad++;
      @(negedge clk);
    end
    total++;
    if (n_bad !== 0) begin bad++; $display("FAIL midreset_quiet: got %0d bad cycles want 0", n_bad); end
    push_msg(0);
    pulse_start(0);
    for (int k = 0; k < 4; k++) check_frame(0);
    total++;
    if (cnt[0] !== 16'd1) begin bad++; $display("FAIL midreset_restart_count: got %0d want 1", cnt[0]); end
  endtask

  task automatic test_parity;
    for (int idx = 1; idx <= 2; idx++) begin
      exp_q.delete();
      push_msg(idx);
      pulse_start(idx);
      check_frame(idx);
      total++;
      if (bsy[idx] !== 1'b0) begin bad++; $display("FAIL parity_busy_end dut%0d: got %b want 0", idx, bsy[idx]); end
      total++;
      if (cnt[idx] !== 16'd1) begin bad++; $display("FAIL parity_count dut%0d: got %0d want 1", idx, cnt[idx]); end
    end
  endtask

  task automatic test_wrap;
    exp_q.delete();
    push_msg(3);
    pulse_start(3);
    check_frame(3);
    check_frame(3);
    total++;
    if (bsy[3] !== 1'b0) begin bad++; $display("FAIL wrap_busy_end: got %b want 0", bsy[3]); end
    total++;
    if (cnt[3] !== 16'd1) begin bad++; $display("FAIL wrap_count: got %0d want 1", cnt[3]); end
  endtask

  task automatic test_continuous;
    int n_gap = 0;
    exp_q.delete();
    mode_s[4] = 1'b1;
    push_msg(4);
    push_msg(4);
    pulse_start(4);
    check_frame(4);
    check_frame(4);
    total++;
    if (cnt[4] !== 16'd1) begin bad++; $display("FAIL cont_count1: got %0d want 1", cnt[4]); end
    for (int i = 0; i < GAP; i++) begin
      if (txd[4] !== 1'b1 || bsy[4] !== 1'b1) n_gap++;
      @(negedge clk);
    end
    total++;
    if (n_gap !== 0) begin bad++; $display("FAIL cont_gap1: got %0d bad cycles want 0", n_gap); end
    check_frame(4);
    mode_s[4] = 1'b0;             // dropped mid-message: finish, then idle
    check_frame(4);
    total++;
    if (bsy[4] !== 1'b0) begin bad++; $display("FAIL cont_stop_busy: got %b want 0", bsy[4]); end
    total++;
    if (cnt[4] !== 16'd2) begin bad++; $display("FAIL cont_count2: got %0d want 2", cnt[4]); end

    // Drop mode_cont in the middle of the gap.
    mode_s[4] = 1'b1;
    push_msg(4);
    pulse_start(4);
    check_frame(4);
    check_frame(4);
    n_gap = 0;
    for (int i = 0; i < GAP; i++) begin
      if (i == GAP / 2) mode_s[4] = 1'b0;
      if (txd[4] !== 1'b1 || bsy[4] !== 1'b1) n_gap++;
      @(negedge clk);
    end
    total++;
    if (n_gap !== 0) begin bad++; $display("FAIL cont_gap2: got %0d bad cycles want 0", n_gap); end
    total++;
    if (bsy[4] !== 1'b0 || txd[4] !== 1'b1) begin
      bad++; $display("FAIL cont_gap_exit: got busy=%b txd=%b want 0 1", bsy[4], txd[4]);
    end
    total++;
    if (cnt[4] !== 16'd3) begin bad++; $display("FAIL cont_count3: got %0d want 3", cnt[4]); end
    n_gap = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd[4] !== 1'b1 || bsy[4] !== 1'b0) n_gap++;
      @(negedge clk);
    end
    total++;
    if (n_gap !== 0) begin bad++; $display("FAIL cont_idle_after: got %0d bad cycles want 0", n_gap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_parity();
    test_wrap();
    test_continuous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
